// File: rtl/snn_pkg.sv
// Shared constants and loader state encoding for the SNN image loader slice.
package snn_pkg;

  localparam int unsigned N_PIXELS   = 784;
  localparam int unsigned PIX_ADDR_W = 10;
  localparam logic [7:0]  ASCII_ZERO = 8'h30;

  // Loader FSM state; kept as plain constants for compatibility with older tools.
  typedef logic [2:0] ld_state_t;

  localparam ld_state_t StLoad     = 3'd0;
  localparam ld_state_t StUnpack   = 3'd1;
  localparam ld_state_t StStart    = 3'd2;
  localparam ld_state_t StWaitDone = 3'd3;
  localparam ld_state_t StTx       = 3'd4;
  localparam ld_state_t StTxWait   = 3'd5;

endpackage

// File: rtl/snn_byte_unpacker.sv
// Byte unpacker: shifts a byte out LSB-first and keeps a one-byte hold buffer so a byte
// arriving mid-unpack is not lost.
module snn_byte_unpacker
  import snn_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data_i,
  input  logic       load_rx_i,    // start a new byte straight from the UART
  input  logic       load_hold_i,  // start a new byte from the hold buffer
  input  logic       hold_wr_i,    // park the UART byte in the hold buffer
  input  logic       shift_i,      // emit one bit this cycle
  output logic       bit_o,
  output logic       we_o,
  output logic       byte_last_o,
  output logic       hold_full_o
);

  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;

  // Next-state for shift register, bit counter and hold buffer; a load wins over a shift.
  always_comb begin
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (load_rx_i) begin
      shreg_d   = rx_data_i;
      bit_cnt_d = 3'd0;
    end else if (load_hold_i) begin
      shreg_d   = hold_q;
      bit_cnt_d = 3'd0;
    end else if (shift_i) begin
      shreg_d   = {1'b0, shreg_q[7:1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    if (hold_wr_i) begin
      hold_d      = rx_data_i;
      hold_full_d = 1'b1;
    end else if (load_hold_i) begin
      hold_full_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  assign bit_o       = shreg_q[0];
  assign we_o        = shift_i;
  assign byte_last_o = (bit_cnt_q == 3'd7);
  assign hold_full_o = hold_full_q;

endmodule

// File: rtl/snn_img_loader.sv
// Image loader: unpacks UART bytes into the 1-bit input RAM, kicks the SNN core, returns the
// classified digit over UART and latches it for the LEDs.
// Build option: ASCII_DIGIT_EN sends the digit as ASCII '0'..'9' instead of a raw nibble.
module snn_img_loader
  import snn_pkg::*;
#(
  parameter int unsigned N_BITS = N_PIXELS,
  parameter int unsigned ADDR_W = PIX_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy_i,
  input  logic [7:0]        rx_data_i,
  output logic              clr_rx_rdy_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_d_o,
  output logic              ram_we_o,
  output logic              core_start_o,
  input  logic              core_done_i,
  input  logic [3:0]        core_digit_i,
  output logic              tx_start_o,
  output logic [7:0]        tx_data_o,
  input  logic              tx_done_i,
  output logic [3:0]        digit_led_o,
  output logic              busy_o,
  output logic              ovr_err_o
);

  localparam int unsigned N_BYTES = N_BITS / 8;
  localparam int unsigned BC_W    = $clog2(N_BYTES + 1);

  function automatic logic [7:0] encode(input logic [3:0] d);
`ifdef ASCII_DIGIT_EN
    return ASCII_ZERO + {4'h0, d};
`else
    return {4'h0, d};
`endif
  endfunction

  ld_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [3:0]        digit_q, digit_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              ovr_q, ovr_d;

  logic load_rx, load_hold, hold_wr, shift;
  logic up_bit, up_we, byte_last, hold_full;

  snn_byte_unpacker u_unpacker (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data_i   (rx_data_i),
    .load_rx_i   (load_rx),
    .load_hold_i (load_hold),
    .hold_wr_i   (hold_wr),
    .shift_i     (shift),
    .bit_o       (up_bit),
    .we_o        (up_we),
    .byte_last_o (byte_last),
    .hold_full_o (hold_full)
  );

  // Loader FSM, pixel address and byte counting, result capture and overrun tracking.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    byte_cnt_d   = byte_cnt_q;
    digit_d      = digit_q;
    tx_data_d    = tx_data_q;
    ovr_d        = ovr_q;
    clr_rx_rdy_o = 1'b0;
    load_rx      = 1'b0;
    load_hold    = 1'b0;
    hold_wr      = 1'b0;
    shift        = 1'b0;
    unique case (state_q)
      StLoad: begin
        // A parked byte goes first; a waiting UART byte stays pending until next cycle.
        if (hold_full) begin
          load_hold = 1'b1;
          state_d   = StUnpack;
        end else if (rx_rdy_i) begin
          load_rx      = 1'b1;
          clr_rx_rdy_o = 1'b1;
          state_d      = StUnpack;
        end
      end
      StUnpack: begin
        shift  = 1'b1;
        addr_d = addr_q + ADDR_W'(1);
        if (rx_rdy_i) begin
          clr_rx_rdy_o = 1'b1;
          if (hold_full) ovr_d = 1'b1;
          else           hold_wr = 1'b1;
        end
        if (byte_last) begin
          byte_cnt_d = byte_cnt_q + BC_W'(1);
          if (byte_cnt_q == BC_W'(N_BYTES - 1)) begin
            // A parked byte survives here and starts the next image.
            state_d = StStart;
          end else if (hold_full) begin
            load_hold = 1'b1;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StStart: begin
        addr_d     = '0;
        byte_cnt_d = '0;
        state_d    = StWaitDone;
      end
      StWaitDone: begin
        if (core_done_i) begin
          digit_d   = core_digit_i;
          tx_data_d = encode(core_digit_i);
          state_d   = StTx;
        end
      end
      StTx: begin
        state_d = StTxWait;
      end
      StTxWait: begin
        if (tx_done_i) state_d = StLoad;
      end
      default: begin
        state_d = StLoad;
      end
    endcase
    // No buffering while the core or transmitter owns the loader: drop and flag.
    if (rx_rdy_i && (state_q != StLoad) && (state_q != StUnpack)) begin
      clr_rx_rdy_o = 1'b1;
      ovr_d        = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StLoad;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      digit_q    <= 4'h0;
      tx_data_q  <= 8'h00;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      digit_q    <= digit_d;
      tx_data_q  <= tx_data_d;
      ovr_q      <= ovr_d;
    end
  end

  assign ram_addr_o   = addr_q;
  assign ram_d_o      = up_bit;
  assign ram_we_o     = up_we;
  assign core_start_o = (state_q == StStart);
  assign tx_start_o   = (state_q == StTx);
  assign tx_data_o    = tx_data_q;
  assign digit_led_o  = digit_q;
  assign busy_o       = (state_q != StLoad);
  assign ovr_err_o    = ovr_q;

endmodule
